// File: rtl/fetch_prefetch_queue_if.sv
// fetch_prefetch_queue_if
//   Bundles the fetch front end's memory, redirect and decode-side signals.
//   master : the fetch unit (drives imem_addr, inst_* and fault)
//   slave  : the environment (memory, PC-source muxes, decode/control)
//   Signals:
//     redirect, redirect_pc        flush and restart fetch at redirect_pc
//     imem_addr, imem_rdata        byte-wide combinational instruction memory
//     inst_valid, inst_ready       head-of-queue handshake
//     inst, inst_pc, inst_pc4      head instruction word and its addresses
//     fault                        misaligned redirect, fetch halted
interface fetch_prefetch_queue_if #(
  parameter int IMEM_AW = 5
);
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [7:0]         imem_rdata;
  logic               inst_valid;
  logic [31:0]        inst;
  logic [31:0]        inst_pc;
  logic [31:0]        inst_pc4;
  logic               inst_ready;
  logic               fault;

  modport master (
    input  redirect, redirect_pc, imem_rdata, inst_ready,
    output imem_addr, inst_valid, inst, inst_pc, inst_pc4, fault
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, inst_ready,
    input  imem_addr, inst_valid, inst, inst_pc, inst_pc4, fault
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//   Instruction fetch front end. Reads one byte per cycle from a byte-wide
//   instruction memory, assembles big-endian 32-bit words, buffers them in a
//   DEPTH-entry FIFO and presents the head over a valid/ready handshake.
//   Owns the 32-bit fetch PC; redirects flush everything and restart fetch.
//   A misaligned redirect halts fetch (fault=1) until an aligned redirect.
//   Ports:
//     clk   clock (posedge)
//     rst   synchronous active-high reset
//     bus   fetch_prefetch_queue_if.master (memory, redirect, decode side)
//   Config macro:
//     FETCH_BYPASS_EN  present a just-assembled word combinationally when the
//                      FIFO is empty, saving one cycle of fetch latency.
module fetch_prefetch_queue #(
  parameter int IMEM_AW = 5,
  parameter int DEPTH   = 4
) (
  input  logic clk,
  input  logic rst,
  fetch_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, HALT} state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [1:0]  bcnt;
  logic [23:0] asm_r;

  entry_t         mem [DEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count;

  logic        empty, full, word_rdy, bypass, byp_take;
  logic        push, pop, advance;
  logic [31:0] word;

  assign word     = {asm_r, bus.imem_rdata};
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign word_rdy = (state == FETCH) && (bcnt == 2'd3);

`ifdef FETCH_BYPASS_EN
  assign bypass   = word_rdy && empty;
`else
  assign bypass   = 1'b0;
`endif

  // A bypassed word that is taken this cycle never touches the FIFO.
  assign byp_take = bypass && bus.inst_ready;
  assign pop      = !empty && bus.inst_ready;
  // Full is fine when the head leaves on the same edge.
  assign push     = word_rdy && !byp_take && (!full || pop);
  assign advance  = push || byp_take;

  assign bus.imem_addr = fetch_pc[IMEM_AW-1:0] + IMEM_AW'(bcnt);
  assign bus.fault     = (state == HALT);

  // Head presentation; zeros when nothing is valid. The FIFO stays empty in
  // HALT because entering HALT always flushes it.
  always_comb begin
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    bus.inst_pc    = '0;
    bus.inst_pc4   = '0;
    if (!empty) begin
      bus.inst_valid = 1'b1;
      bus.inst       = mem[head].word;
      bus.inst_pc    = mem[head].pc;
      bus.inst_pc4   = mem[head].pc + 32'd4;
    end else if (bypass) begin
      bus.inst_valid = 1'b1;
      bus.inst       = word;
      bus.inst_pc    = fetch_pc;
      bus.inst_pc4   = fetch_pc + 32'd4;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // FSM: next state; only a redirect can move it
  always_comb begin
    state_nxt = state;
    if (bus.redirect)
      state_nxt = (bus.redirect_pc[1:0] != 2'b00) ? HALT : FETCH;
  end

  // Fetch PC, byte assembly and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= '0;
      bcnt     <= '0;
      asm_r    <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      // Drops queued words and the partial word; a coincident pop is simply
      // absorbed by the flush.
      fetch_pc <= bus.redirect_pc;
      bcnt     <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (state == FETCH) begin
        case (bcnt)
          2'd0: begin asm_r[23:16] <= bus.imem_rdata; bcnt <= 2'd1; end
          2'd1: begin asm_r[15:8]  <= bus.imem_rdata; bcnt <= 2'd2; end
          2'd2: begin asm_r[7:0]   <= bus.imem_rdata; bcnt <= 2'd3; end
          default: begin
            // bcnt and fetch_pc hold (so does imem_addr) until the word goes
            if (advance) begin
              fetch_pc <= fetch_pc + 32'd4;
              bcnt     <= 2'd0;
            end
          end
        endcase
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity lives in count.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{word: word, pc: fetch_pc};
  end
endmodule
